// File: rtl/serial_imem_streamer.sv
// serial_imem_streamer: byte-writable little-endian instruction memory that streams one fetched word to a bit-serial core
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset (memory contents survive reset)
//   we/waddr/wdata     byte write port, writes at or beyond NBYTES are dropped
//   fetch_req/addr     level fetch request with the byte address of the word's LSB (taken only in IDLE)
//   fetch_ack          one-cycle pulse: fetch accepted, stream starts in the same cycle
//   addr_err           one-cycle pulse: misaligned or out-of-range fetch rejected
//   busy               high while streaming or in the execute gap
//   word_out           parallel copy of the last accepted word
//   ser_valid/data/    LSB-first beats of LANES bits under a valid/ready handshake,
//   ser_ready/last     ser_last marks the final beat
//   done               one-cycle pulse when the execute gap ends
//
// Build option: define IMEM_PARITY_EN to append an even-parity beat after the data beats.
module serial_imem_streamer #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 16,
  parameter int LANES       = 1,
  parameter int ADDR_W      = 32,
  parameter int GAP_CYCLES  = 66
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic              addr_err,
  output logic              busy,
  output logic [XLEN-1:0]   word_out,
  output logic              ser_valid,
  output logic [LANES-1:0]  ser_data,
  input  logic              ser_ready,
  output logic              ser_last,
  output logic              done
);
  localparam int WB     = XLEN / 8;
  localparam int NBYTES = DEPTH_WORDS * WB;
  localparam int BEATS  = XLEN / LANES;
`ifdef IMEM_PARITY_EN
  localparam int NB = BEATS + 1;
`else
  localparam int NB = BEATS;
`endif
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W:0] WB_A     = (ADDR_W + 1)'(WB);
  localparam logic [ADDR_W:0] NBYTES_A = (ADDR_W + 1)'(NBYTES);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t            state;
  logic [XLEN-1:0]   mem [DEPTH_WORDS];
  logic [XLEN-1:0]   sreg;
  logic [XLEN-1:0]   word;
  logic [IW-1:0]     w_idx, f_idx;
  logic [ADDR_W-1:0] w_lane, f_lane;
  logic              w_ok, f_ok;
  logic [BW-1:0]     beat, next_beat;
  logic [GW-1:0]     gcnt;
  logic [LANES-1:0]  nxt_data;
`ifdef IMEM_PARITY_EN
  logic              par;
`endif

  // Memory is stored as words; a byte address splits into word index and byte lane.
  assign w_idx     = IW'(waddr / ADDR_W'(WB));
  assign w_lane    = waddr % ADDR_W'(WB);
  assign w_ok      = {1'b0, waddr} < NBYTES_A;
  assign f_idx     = IW'(fetch_addr / ADDR_W'(WB));
  assign f_lane    = fetch_addr % ADDR_W'(WB);
  // Widened by one bit so the end-of-word check cannot overflow near the top of the address space.
  assign f_ok      = f_lane == '0 && {1'b0, fetch_addr} + WB_A <= NBYTES_A;
  assign word      = mem[f_idx];
  assign next_beat = beat + BW'(1);
`ifdef IMEM_PARITY_EN
  assign nxt_data  = next_beat == BW'(BEATS) ? LANES'(par) : sreg[LANES-1:0];
`else
  assign nxt_data  = sreg[LANES-1:0];
`endif

  // The fetch reads the array before this edge's write lands, so a same-edge write is not seen.
  always_ff @(posedge clk)
    for (int i = 0; i < WB; i++)
      if (we && w_ok && w_lane == ADDR_W'(i)) mem[w_idx][i*8 +: 8] <= wdata;

  // The stream works from a private shifted copy, so later writes never disturb an in-flight word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fetch_ack <= 1'b0;
      addr_err  <= 1'b0;
      busy      <= 1'b0;
      word_out  <= '0;
      ser_valid <= 1'b0;
      ser_data  <= '0;
      ser_last  <= 1'b0;
      done      <= 1'b0;
      beat      <= '0;
      gcnt      <= '0;
      sreg      <= '0;
`ifdef IMEM_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      fetch_ack <= 1'b0;
      addr_err  <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: if (fetch_req) begin
          if (f_ok) begin
            state     <= SHIFT;
            fetch_ack <= 1'b1;
            busy      <= 1'b1;
            word_out  <= word;
            sreg      <= word >> LANES;
            ser_valid <= 1'b1;
            ser_data  <= word[LANES-1:0];
            ser_last  <= NB == 1;
            beat      <= '0;
`ifdef IMEM_PARITY_EN
            par       <= ^word;
`endif
          end else begin
            addr_err  <= 1'b1;
          end
        end
        SHIFT: if (ser_ready) begin
          if (beat == BW'(NB - 1)) begin
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            ser_data  <= '0;
            gcnt      <= '0;
            state     <= GAP_CYCLES == 0 ? IDLE : GAP;
            busy      <= GAP_CYCLES != 0;
            done      <= GAP_CYCLES == 0;
          end else begin
            beat      <= next_beat;
            ser_data  <= nxt_data;
            sreg      <= sreg >> LANES;
            ser_last  <= next_beat == BW'(NB - 1);
          end
        end
        GAP: if (gcnt == GW'(GAP_CYCLES - 1)) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          gcnt  <= gcnt + GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_imem_streamer.sv
// tb_serial_imem_streamer: two streamers (1-bit and 4-bit lanes) against a queue-based model plus literal checks
module tb_serial_imem_streamer;
  localparam int G = 66;
`ifdef IMEM_PARITY_EN
  localparam int PX = 1;
`else
  localparam int PX = 0;
`endif

  logic        clk = 0, reset = 1, we = 0, fetch_req = 0, ser_ready = 1;
  logic [31:0] waddr = 0, fetch_addr = 0;
  logic [7:0]  wdata = 0;
  logic [1:0]  ack, err, bsy, sv, sl, dn;
  logic [31:0] wo [2];
  logic        sd1;
  logic [3:0]  sd4;

  serial_imem_streamer #(.LANES(1), .GAP_CYCLES(G)) u1 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(ack[0]), .addr_err(err[0]),
    .busy(bsy[0]), .word_out(wo[0]), .ser_valid(sv[0]), .ser_data(sd1), .ser_ready(ser_ready),
    .ser_last(sl[0]), .done(dn[0]));

  serial_imem_streamer #(.LANES(4), .GAP_CYCLES(G)) u4 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(ack[1]), .addr_err(err[1]),
    .busy(bsy[1]), .word_out(wo[1]), .ser_valid(sv[1]), .ser_data(sd4), .ser_ready(ser_ready),
    .ser_last(sl[1]), .done(dn[1]));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a byte array, and per instance a queue of pending beats plus a gap countdown.
  logic [7:0]  mm [64] = '{default: 8'h00};
  int          qv [2][40];
  int          qh [2], qn [2], gl [2];
  logic [1:0]  e_ack, e_err, e_done;
  logic [31:0] e_wo [2];

  always @(posedge clk) begin
    logic [31:0] w;
    int l, nb;
    for (int k = 0; k < 2; k++) begin
      l = k == 0 ? 1 : 4;
      nb = 32 / l;
      e_ack[k] = 0; e_err[k] = 0; e_done[k] = 0;
      if (reset) begin
        qn[k] = 0; gl[k] = 0; e_wo[k] = 0;
      end else if (qn[k] > 0) begin
        if (ser_ready) begin
          qh[k]++; qn[k]--;
          if (qn[k] == 0) begin
            if (G == 0) e_done[k] = 1; else gl[k] = G;
          end
        end
      end else if (gl[k] > 0) begin
        gl[k]--;
        if (gl[k] == 0) e_done[k] = 1;
      end else if (fetch_req) begin
        if (fetch_addr % 4 == 0 && fetch_addr + 4 <= 64) begin
          w = {mm[fetch_addr+3], mm[fetch_addr+2], mm[fetch_addr+1], mm[fetch_addr]};
          e_wo[k] = w; e_ack[k] = 1;
          for (int i = 0; i < nb; i++) qv[k][i] = int'((w >> (i * l)) & ((32'd1 << l) - 1));
          qv[k][nb] = int'(^w);
          qh[k] = 0; qn[k] = nb + PX;
        end else e_err[k] = 1;
      end
    end
    if (we && waddr < 64) mm[waddr] = wdata;
  end

  // Trace of observed DUT behaviour, read by the literal checks.
  int bt [2][1024];
  int nbeat [2], last_idx [2], last_cyc [2], done_cnt [2], done_cyc [2], ack_cyc [2], err_cnt [2], bsy_cnt [2];

  always @(negedge clk) begin
    logic [3:0] a_sd;
    for (int k = 0; k < 2; k++) begin
      a_sd = k == 0 ? {3'b000, sd1} : sd4;
      chk($sformatf("u%0d_fetch_ack", k), 32'(ack[k]), 32'(e_ack[k]));
      chk($sformatf("u%0d_addr_err", k), 32'(err[k]), 32'(e_err[k]));
      chk($sformatf("u%0d_done", k), 32'(dn[k]), 32'(e_done[k]));
      chk($sformatf("u%0d_busy", k), 32'(bsy[k]), 32'(qn[k] > 0 || gl[k] > 0));
      chk($sformatf("u%0d_ser_valid", k), 32'(sv[k]), 32'(qn[k] > 0));
      chk($sformatf("u%0d_ser_data", k), 32'(a_sd), qn[k] > 0 ? 32'(qv[k][qh[k]]) : 32'd0);
      chk($sformatf("u%0d_ser_last", k), 32'(sl[k]), 32'(qn[k] == 1));
      chk($sformatf("u%0d_word_out", k), wo[k], e_wo[k]);
      if (ack[k]) ack_cyc[k] = cyc;
      if (err[k]) err_cnt[k]++;
      if (bsy[k]) bsy_cnt[k]++;
      if (dn[k]) begin done_cnt[k]++; done_cyc[k] = cyc; end
      if (sv[k] && ser_ready) begin
        if (nbeat[k] < 1024) bt[k][nbeat[k]] = int'(a_sd);
        if (sl[k]) begin last_idx[k] = nbeat[k]; last_cyc[k] = cyc; end
        nbeat[k]++;
      end
    end
  end

  int base [2];
  int rc;

  task automatic tick;
    @(negedge clk); #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    we = 1; waddr = a; wdata = d; tick; we = 0;
  endtask

  task automatic wr_word(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) wr(a + i, w[i*8 +: 8]);
  endtask

  task automatic fetch(input int a);
    fetch_addr = a; fetch_req = 1;
    base[0] = nbeat[0]; base[1] = nbeat[1]; rc = cyc;
    tick;
    fetch_req = 0;
  endtask

  task automatic wait_done(input bit tog);
    int d0, d1, t;
    d0 = done_cnt[0]; d1 = done_cnt[1]; t = 0;
    while ((done_cnt[0] == d0 || done_cnt[1] == d1) && t < 600) begin
      if (tog) ser_ready = ~ser_ready;
      tick; t++;
    end
    ser_ready = 1;
    if (t >= 600) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_done: no done after %0d cycles, required within 600", t);
    end
  endtask

  function automatic logic [31:0] pack(input int k, input int n);
    logic [31:0] r = 0;
    int l = k == 0 ? 1 : 4;
    for (int i = 0; i < n; i++) r = r | (32'(bt[k][base[k] + i]) << (i * l));
    return r;
  endfunction

  initial begin
    int e0, e1, b0, b1, n0, n1, d0, d1, t;
    repeat (3) tick;
    reset = 0;
    chk("reset_ctrl", {26'd0, ack, err, bsy}, 32'd0);
    chk("reset_stream", {22'd0, sv, sl, dn, sd1, sd4}, 32'd0);
    chk("reset_word_out", wo[0] | wo[1], 32'd0);

    wr(0, 8'h93); wr(1, 8'h02); wr(2, 8'h20); wr(3, 8'h00);
    fetch(0);
    wait_done(0);
    chk("t1_ack_latency", ack_cyc[0] - rc, 1);
    chk("t1_word_out_l1", wo[0], 32'h00200293);
    chk("t1_word_out_l4", wo[1], 32'h00200293);
    chk("t1_first8_bits", pack(0, 8), 32'h93);
    chk("t1_all_bits", pack(0, 32), 32'h00200293);
    chk("t1_beat_count", nbeat[0] - base[0], 32 + PX);
    chk("t1_last_beat", last_idx[0] - base[0], 31 + PX);
    chk("t1_gap_len", done_cyc[0] - last_cyc[0], G + 1);

    wr_word(40, 32'hFFC6C2E3);
    fetch(40);
    wait_done(1);
    chk("t2_nibbles", pack(1, 8), 32'hFFC6C2E3);
    chk("t2_nibble_last", last_idx[1] - base[1], 7 + PX);
    chk("t2_nibble_count", nbeat[1] - base[1], 8 + PX);
    chk("t2_bits_l1", pack(0, 32), 32'hFFC6C2E3);

    e0 = err_cnt[0]; e1 = err_cnt[1]; b0 = bsy_cnt[0]; b1 = bsy_cnt[1];
    n0 = nbeat[0]; n1 = nbeat[1];
    fetch(2); tick;
    chk("t3_misaligned_err", err_cnt[0] - e0, 1);
    fetch(64); tick;
    chk("t3_oob_err", err_cnt[1] - e1, 2);
    chk("t3_no_busy", (bsy_cnt[0] - b0) + (bsy_cnt[1] - b1), 0);
    chk("t3_no_beats", (nbeat[0] - n0) + (nbeat[1] - n1), 0);
    chk("t3_word_kept", wo[0], 32'hFFC6C2E3);
    wr_word(60, 32'h12345678);
    fetch(60);
    wait_done(0);
    chk("t3_top_word", wo[1], 32'h12345678);

    we = 1; waddr = 0; wdata = 8'hAA;
    fetch(0);
    we = 0;
    wait_done(0);
    chk("t4_old_byte", wo[0], 32'h00200293);
    chk("t4_old_stream", pack(1, 8), 32'h00200293);
    fetch(0);
    wait_done(0);
    chk("t4_new_byte", wo[0], 32'h002002AA);

    d0 = done_cnt[0]; d1 = done_cnt[1];
    fetch(0);
    t = 0;
    while (nbeat[0] - base[0] < 10 && t < 100) begin tick; t++; end
    if (t >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL t5_reach_beat10: waited %0d cycles, required under 100", t);
    end
    reset = 1; tick; reset = 0;
    chk("t5_ctrl_cleared", {26'd0, ack, err, bsy}, 32'd0);
    chk("t5_stream_cleared", {22'd0, sv, sl, dn, sd1, sd4}, 32'd0);
    chk("t5_word_cleared", wo[0] | wo[1], 32'd0);
    repeat (100) tick;
    chk("t5_no_done", (done_cnt[0] - d0) + (done_cnt[1] - d1), 0);
    fetch(0);
    wait_done(0);
    chk("t5_mem_kept", wo[0], 32'h002002AA);

    wr_word(8, 32'h00000007);
    wr_word(12, 32'h00000003);
    fetch(8);
    wait_done(0);
    chk("t6_word7", wo[0], 32'h00000007);
`ifdef IMEM_PARITY_EN
    chk("t6_par7_l1", bt[0][base[0] + 32], 1);
    chk("t6_par7_last", last_idx[0] - base[0], 32);
    chk("t6_par7_l4", bt[1][base[1] + 8], 1);
`endif
    fetch(12);
    wait_done(0);
    chk("t6_word3", wo[1], 32'h00000003);
`ifdef IMEM_PARITY_EN
    chk("t6_par3_l1", bt[0][base[0] + 32], 0);
    chk("t6_par3_l4", bt[1][base[1] + 8], 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_imem_streamer.md
Name: serial_imem_streamer

Overview:
Parametrised, byte-addressed, little-endian instruction memory that serialises one fetched instruction word to the bit-serial core. It streams LANES bits per beat under a valid/ready handshake. After the stream it holds an execute gap, then accepts the next fetch. A byte write port loads the program at run time, so program contents are not hard-coded.

Parameters:
XLEN, 32, instruction width in bits; multiple of 8.
DEPTH_WORDS, 16, storage depth in XLEN-bit words; byte capacity NBYTES = DEPTH_WORDS*XLEN/8.
LANES, 1, bits per serial beat; must divide XLEN; BEATS = XLEN/LANES.
ADDR_W, 32, byte address width.
GAP_CYCLES, 66, idle cycles after the last beat before the next fetch is accepted; 0 is legal.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
we  in  1  byte write enable
waddr  in  ADDR_W  byte write address
wdata  in  8  write byte
fetch_req  in  1  request a fetch (level)
fetch_addr  in  ADDR_W  byte address of the word's LSB
fetch_ack  out  1  one-cycle pulse: fetch accepted
addr_err  out  1  one-cycle pulse: fetch rejected
busy  out  1  high outside IDLE
word_out  out  XLEN  latched parallel copy of the fetched word
ser_valid  out  1  serial beat valid
ser_data  out  LANES  current beat
ser_ready  in  1  consumer accepts beat
ser_last  out  1  final beat of the word
done  out  1  one-cycle pulse when the gap ends

Behaviour:
- Reset is synchronous, active-high, on clk. It clears state to IDLE. All outputs reset to 0: fetch_ack, addr_err, busy, word_out, ser_valid, ser_data, ser_last, done. Reset does not clear the byte array.
- Writes: on every edge where we=1 and waddr<NBYTES, mem[waddr]<=wdata. Writes with waddr>=NBYTES are ignored. Writes are legal in every state.
- Word assembly: word = {mem[a+XLEN/8-1], ..., mem[a+1], mem[a]}.
- States: IDLE, SHIFT, GAP.
- IDLE, fetch_req=1:
  - Legal address (a % (XLEN/8)==0 and a+XLEN/8<=NBYTES): latch word into word_out and the shift register, go to SHIFT, pulse fetch_ack the next cycle.
  - Illegal address: pulse addr_err, stay in IDLE, leave word_out unchanged.
- fetch_req outside IDLE is ignored, with no ack and no error.
- SHIFT:
  - ser_valid=1 and ser_data = word[beat*LANES +: LANES], with beat counting from 0 (LSB first).
  - beat increments only on a cycle with ser_valid&&ser_ready. ser_data is held stable while ser_ready=0.
  - ser_last=1 when beat==BEATS-1.
  - The accepted last beat moves to GAP. If GAP_CYCLES==0, it moves to IDLE and pulses done.
- GAP: count GAP_CYCLES cycles with ser_valid=0, then pulse done and return to IDLE. A new fetch is accepted on the cycle after done at the earliest.
- Same-edge write and fetch to the same byte: the fetch captures the old byte. Writes during SHIFT/GAP never alter the in-flight word.
- Reset mid-SHIFT or mid-GAP aborts immediately, with no done pulse.
- Beat and gap counters are sized by $clog2 and never wrap within a word.

Optional Feature:
IMEM_PARITY_EN
- Defined: the stream gains one extra beat after the data beats, for BEATS+1 beats total.
  - On that beat, ser_data[0] = ^word (even parity) and the upper lanes are 0.
  - ser_last moves to the parity beat.
  - The parity beat obeys the same ready handshake.
- Undefined: BEATS data beats only, with no parity logic.

Test Plan:
1. Load bytes 93,02,20,00 at 0..3; LANES=1; fetch 0, ready=1 -> fetch_ack next cycle; word_out=0x00200293; ser_data beats 0..7 = 1,1,0,0,1,0,0,1; ser_last on beat 31; done exactly GAP_CYCLES cycles later.
2. LANES=4, word 0xFFC6C2E3 at 40; ser_ready toggles 1,0,1,0 -> nibbles 3,E,2,C,6,C,F,F, each held while ready=0; ser_last on the 8th nibble.
3. Fetch addr 2 (misaligned) or addr NBYTES -> one addr_err pulse, busy stays 0, word_out unchanged, no ser_valid.
4. Write 0xAA to byte 0 on the same edge as fetch 0 -> streamed word holds the old byte; a second fetch shows 0xAA in bits 7:0.
5. Assert reset at beat 10 of SHIFT -> next cycle all outputs 0, state IDLE, no done; memory keeps its contents (refetch returns the same word).
6. IMEM_PARITY_EN, word 0x00000007 -> 33 beats, parity beat ser_data=1 with ser_last=1; word 0x00000003 -> parity beat 0.
